// File: rtl/wb_spi_top_level.sv
// wb_spi_top_level
//   Wishbone slave SPI master for a serial EEPROM (25LC020A class).
//   SPI mode 0 (SCK idles low, sample on rising edge, shift on falling edge),
//   MSB first, 8-bit frames. The slave select is driven from software only.
//
//   Register map (full 32-bit address compare, every access is acked):
//     ADDR_DATA  W: TX byte, starts a frame when enabled and idle
//                R: the readback below
//     ADDR_CTRL  W: [7:0] DIV, [8] IFC, [10] IE, [11] SSE, [12] EN
//   Readback on wb_din, independent of the address:
//     [13] BUSY, [12] EN, [11] SSE, [10] IE, [9] IF, [7:0] RX, all other bits 0
//
// Ports
//   clk       system clock, rising edge
//   rst       asynchronous reset, active low
//   wb_addr   Wishbone address
//   wb_we     write enable
//   wb_stb    strobe
//   wb_cyc    bus cycle
//   wb_dout   write data from the bus master
//   wb_din    read data to the bus master (continuous)
//   wb_ack    registered single-cycle acknowledge
//   spi_mosi  serial data out
//   spi_sck   serial clock, idle low
//   spi_ss    slave select, active low
//   spi_miso  serial data in
//   irq       interrupt, IF & IE & EN
module wb_spi_top_level #(
  parameter logic [31:0] ADDR_DATA = 32'h10,
  parameter logic [31:0] ADDR_CTRL = 32'h20
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] wb_addr,
  input  logic        wb_we,
  input  logic        wb_stb,
  input  logic        wb_cyc,
  input  logic [31:0] wb_dout,
  output logic [31:0] wb_din,
  output logic        wb_ack,
  output logic        spi_mosi,
  output logic        spi_sck,
  output logic        spi_ss,
  input  logic        spi_miso,
  output logic        irq
);

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StDone
  } state_e;

  state_e     state_q, state_d;

  // CTRL fields
  logic [7:0] div_q, div_d;
  logic       ie_q, ie_d;
  logic       sse_q, sse_d;
  logic       en_q, en_d;

  // Status and data
  logic       if_q, if_d;
  logic [7:0] rx_q, rx_d;

  // Shift engine
  logic [7:0] sr_q, sr_d;        // TX bits leave at the top, RX bits enter at the bottom
  logic [7:0] cur_div_q, cur_div_d;
  logic [7:0] cnt_q, cnt_d;      // clk cycles within the current half-period
  logic [3:0] half_q, half_d;    // half-period index 0..15
  logic       sck_q, sck_d;
  logic       mosi_q, mosi_d;

  logic       ack_q, ack_d;

  logic       wr_commit;
  logic       ctrl_wr;
  logic       data_wr;
  logic       half_end;
  logic       busy;
  logic       unused_wb_dout;

  // A write commits only on the edge where ack rises, so a held strobe
  // cannot write twice within one acked access.
  assign wr_commit = wb_stb & wb_cyc & wb_we & ~ack_q;
  assign ctrl_wr   = wr_commit & (wb_addr == ADDR_CTRL);
  assign data_wr   = wr_commit & (wb_addr == ADDR_DATA);
  assign half_end  = (cnt_q == cur_div_q);
  assign busy      = (state_q != StIdle);

  // Write-data bits that have no CTRL field
  assign unused_wb_dout = ^{wb_dout[31:13], wb_dout[9]};

  always_comb begin
    state_d   = state_q;
    div_d     = div_q;
    ie_d      = ie_q;
    sse_d     = sse_q;
    en_d      = en_q;
    if_d      = if_q;
    rx_d      = rx_q;
    sr_d      = sr_q;
    cur_div_d = cur_div_q;
    cnt_d     = cnt_q;
    half_d    = half_q;
    sck_d     = sck_q;
    mosi_d    = mosi_q;
    ack_d     = wb_stb & wb_cyc & ~ack_q;

    if (ctrl_wr) begin
      div_d = wb_dout[7:0];
      ie_d  = wb_dout[10];
      sse_d = wb_dout[11];
      en_d  = wb_dout[12];
      if (wb_dout[8]) begin
        if_d = 1'b0;
      end
    end

    unique case (state_q)
      StIdle: begin
        if (data_wr && en_q) begin
          state_d   = StShift;
          sr_d      = wb_dout[7:0];
          mosi_d    = wb_dout[7];
          cur_div_d = div_q;
          cnt_d     = 8'd0;
          half_d    = 4'd0;
          sck_d     = 1'b0;
          if_d      = 1'b0;
        end
      end

      StShift: begin
        if (!en_q) begin
          // Abort: IF and RX are left as they were
          state_d = StIdle;
          sck_d   = 1'b0;
        end else if (half_end) begin
          cnt_d  = 8'd0;
          half_d = half_q + 4'd1;
          sck_d  = ~sck_q;
          if (!sck_q) begin
            // Rising SCK edge: sample MISO
            sr_d = {sr_q[6:0], spi_miso};
          end else if (half_q != 4'd15) begin
            // Falling SCK edge: present the next bit; after the last one MOSI holds
            mosi_d = sr_q[7];
          end
          if (half_q == 4'd15) begin
            state_d = StDone;
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end

      StDone: begin
        // Frame end sets IF even if an IFC write lands on the same edge
        rx_d    = sr_q;
        if_d    = 1'b1;
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
        sck_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= StIdle;
      div_q     <= 8'd0;
      ie_q      <= 1'b0;
      sse_q     <= 1'b0;
      en_q      <= 1'b0;
      if_q      <= 1'b0;
      rx_q      <= 8'd0;
      sr_q      <= 8'd0;
      cur_div_q <= 8'd0;
      cnt_q     <= 8'd0;
      half_q    <= 4'd0;
      sck_q     <= 1'b0;
      mosi_q    <= 1'b0;
      ack_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      ie_q      <= ie_d;
      sse_q     <= sse_d;
      en_q      <= en_d;
      if_q      <= if_d;
      rx_q      <= rx_d;
      sr_q      <= sr_d;
      cur_div_q <= cur_div_d;
      cnt_q     <= cnt_d;
      half_q    <= half_d;
      sck_q     <= sck_d;
      mosi_q    <= mosi_d;
      ack_q     <= ack_d;
    end
  end

  assign wb_ack   = ack_q;
  assign spi_sck  = sck_q;
  assign spi_mosi = mosi_q;
  assign spi_ss   = ~(sse_q & en_q);
  assign irq      = if_q & ie_q & en_q;
  assign wb_din   = {16'h0000, 2'b00, busy, en_q, sse_q, ie_q, if_q, 1'b0, rx_q};

endmodule

// File: tb/tb_wb_spi_top_level.sv
// Self-checking bench for wb_spi_top_level: register-access vector table,
// directed SPI frames against a small 25LC020A-style EEPROM model, randomized
// frames against a byte-level slave, plus abort, busy-write and reset corners.
module tb_wb_spi_top_level;

  localparam logic [31:0] A_DATA = 32'h10;
  localparam logic [31:0] A_CTRL = 32'h20;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] wb_addr = '0;
  logic        wb_we = 1'b0;
  logic        wb_stb = 1'b0;
  logic        wb_cyc = 1'b0;
  logic [31:0] wb_dout = '0;
  logic [31:0] wb_din;
  logic        wb_ack;
  logic        spi_mosi;
  logic        spi_sck;
  logic        spi_ss;
  logic        spi_miso;
  logic        irq;

  wb_spi_top_level dut (
    .clk      (clk),
    .rst      (rst),
    .wb_addr  (wb_addr),
    .wb_we    (wb_we),
    .wb_stb   (wb_stb),
    .wb_cyc   (wb_cyc),
    .wb_dout  (wb_dout),
    .wb_din   (wb_din),
    .wb_ack   (wb_ack),
    .spi_mosi (spi_mosi),
    .spi_sck  (spi_sck),
    .spi_ss   (spi_ss),
    .spi_miso (spi_miso),
    .irq      (irq)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Cycle counter and SCK monitor
  int         cyc = 0;
  int         n_rise = 0;
  int         last_rise = 0;
  int         rise_period = 0;
  logic [7:0] mosi_cap = '0;

  always @(posedge clk) cyc++;

  always @(posedge spi_sck) begin
    mosi_cap = {mosi_cap[6:0], spi_mosi};
    if (n_rise > 0) rise_period = cyc - last_rise;
    last_rise = cyc;
    n_rise++;
  end

  // Byte-level slave: returns slv_sr MSB first, changing on falling SCK
  logic [7:0] slv_sr = '0;
  logic       use_ee = 1'b0;

  always @(negedge spi_sck) slv_sr = {slv_sr[6:0], 1'b0};

  // EEPROM model: WREN 06, WRITE 02 addr data..., READ 03 addr
  logic [7:0] ee_mem [256];
  logic [7:0] ee_in = '0;
  logic [7:0] ee_out = '0;
  logic [7:0] ee_next = '0;
  logic [7:0] ee_cmd = '0;
  logic [7:0] ee_adr = '0;
  logic       ee_wel = 1'b0;
  int         ee_bits = 0;
  int         ee_byte = 0;

  initial for (int i = 0; i < 256; i++) ee_mem[i] = 8'h00;

  always @(negedge spi_ss) begin
    ee_bits = 0;
    ee_byte = 0;
    ee_out  = '0;
  end

  always @(posedge spi_ss) if (ee_cmd == 8'h02) ee_wel = 1'b0;

  always @(posedge spi_sck) begin
    if (!spi_ss) begin
      ee_in = {ee_in[6:0], spi_mosi};
      ee_bits++;
      if (ee_bits == 8) begin
        ee_bits = 0;
        ee_next = 8'h00;
        if (ee_byte == 0) begin
          ee_cmd = ee_in;
          if (ee_in == 8'h06) ee_wel = 1'b1;
          if (ee_in == 8'h04) ee_wel = 1'b0;
        end else if (ee_byte == 1) begin
          ee_adr = ee_in;
          if (ee_cmd == 8'h03) ee_next = ee_mem[ee_adr];
        end else begin
          if (ee_cmd == 8'h02 && ee_wel) begin
            ee_mem[ee_adr] = ee_in;
            ee_adr = ee_adr + 8'd1;
          end else if (ee_cmd == 8'h03) begin
            ee_adr = ee_adr + 8'd1;
            ee_next = ee_mem[ee_adr];
          end
        end
        ee_byte++;
      end
    end
  end

  always @(negedge spi_sck) begin
    if (!spi_ss) begin
      if (ee_bits == 0) ee_out = ee_next;
      else ee_out = {ee_out[6:0], 1'b0};
    end
  end

  assign spi_miso = use_ee ? ee_out[7] : slv_sr[7];

  // One Wishbone access; ack must appear exactly one cycle after strobe, for one cycle
  task automatic bus(input logic [31:0] a, input logic we, input logic [31:0] d);
    @(negedge clk);
    wb_addr = a; wb_we = we; wb_dout = d; wb_stb = 1'b1; wb_cyc = 1'b1;
    @(posedge clk); #1;
    check("ack_rise", wb_ack, 1);
    wb_stb = 1'b0; wb_cyc = 1'b0; wb_we = 1'b0;
    @(posedge clk); #1;
    check("ack_pulse", wb_ack, 0);
  endtask

  task automatic start_frame(input logic [7:0] tx, input logic [7:0] slv);
    slv_sr = slv;
    n_rise = 0;
    @(negedge clk);
    wb_addr = A_DATA; wb_we = 1'b1; wb_dout = {24'h0, tx}; wb_stb = 1'b1; wb_cyc = 1'b1;
    @(posedge clk); #1;
    check("data_ack", wb_ack, 1);
    check("mosi_msb", spi_mosi, tx[7]);
    check("busy_set", wb_din[13], 1);
    check("if_clr_on_start", wb_din[9], 0);
    wb_stb = 1'b0; wb_cyc = 1'b0; wb_we = 1'b0;
  endtask

  task automatic finish_frame(input logic [7:0] tx, input int div, input bit chk_rx,
                              input logic [7:0] exp_rx);
    int k = 0;
    while (!wb_din[9] && k < 16 * (div + 1) + 20) begin
      @(posedge clk); #1;
      k++;
    end
    check("if_set", wb_din[9], 1);
    check("sck_pulses", n_rise, 8);
    check("mosi_seq", mosi_cap, tx);
    check("sck_period", rise_period, 2 * (div + 1));
    check("sck_idle", spi_sck, 0);
    check("busy_clr", wb_din[13], 0);
    check("mosi_hold", spi_mosi, tx[0]);
    if (chk_rx) check("rx_byte", wb_din[7:0], exp_rx);
  endtask

  task automatic frame(input logic [7:0] tx, input logic [7:0] slv, input int div,
                       input bit chk_rx, input logic [7:0] exp_rx);
    start_frame(tx, slv);
    finish_frame(tx, div, chk_rx, exp_rx);
  endtask

  typedef struct {
    logic [31:0] a;
    logic        we;
    logic [31:0] d;
    logic [15:0] exp;
    logic        ss;
    logic        irq;
  } vec_t;

  vec_t vecs [8];

  initial begin
    logic [7:0] tx, slv, rx_prev;
    int         div;
    logic       ie;
    logic [7:0] rd_tx [5];
    logic [7:0] rd_exp [5];

    vecs[0] = '{A_CTRL,        1'b1, 32'h0000_1800, 16'h1800, 1'b0, 1'b0};
    vecs[1] = '{A_CTRL,        1'b0, 32'hFFFF_FFFF, 16'h1800, 1'b0, 1'b0};
    vecs[2] = '{A_CTRL,        1'b1, 32'h0000_0800, 16'h0800, 1'b1, 1'b0};
    vecs[3] = '{A_CTRL,        1'b1, 32'hFFFF_E4FF, 16'h0400, 1'b1, 1'b0};
    vecs[4] = '{32'h0000_0030, 1'b1, 32'hFFFF_FFFF, 16'h0400, 1'b1, 1'b0};
    vecs[5] = '{A_DATA,        1'b1, 32'h0000_00AB, 16'h0400, 1'b1, 1'b0};
    vecs[6] = '{32'h8000_0020, 1'b1, 32'h0000_1800, 16'h0400, 1'b1, 1'b0};
    vecs[7] = '{A_CTRL,        1'b1, 32'h0000_1400, 16'h1400, 1'b1, 1'b0};

    // Reset state
    repeat (20) @(posedge clk);
    #1;
    check("rst_ss", spi_ss, 1);
    check("rst_sck", spi_sck, 0);
    check("rst_irq", irq, 0);
    check("rst_din", wb_din, 0);
    check("rst_ack", wb_ack, 0);
    check("rst_mosi", spi_mosi, 0);
    @(negedge clk);
    rst = 1'b1;

    // Register access table
    for (int i = 0; i < 8; i++) begin
      bus(vecs[i].a, vecs[i].we, vecs[i].d);
      check("vec_din", wb_din, {16'h0, vecs[i].exp});
      check("vec_ss", spi_ss, vecs[i].ss);
      check("vec_irq", irq, vecs[i].irq);
    end

    // Slowest divider, WREN byte also reaches the EEPROM
    slv = 8'($urandom);
    bus(A_CTRL, 1'b1, 32'hFFFF_FEFF);
    check("t2_ss", spi_ss, 0);
    frame(8'h06, slv, 255, 1'b1, slv);
    check("t2_din", wb_din, {16'h0, 8'h1E, slv});
    check("t2_irq", irq, 1);

    // IFC clears IF, SSE off raises ss
    bus(A_CTRL, 1'b1, 32'hFFFF_F3FF);
    check("t3_if", wb_din[9], 0);
    check("t3_irq", irq, 0);
    check("t3_ss", spi_ss, 1);

    // EEPROM page write
    bus(A_CTRL, 1'b1, 32'h0000_1C01);
    frame(8'h02, 8'h00, 1, 1'b0, 8'h00);
    frame(8'h10, 8'h00, 1, 1'b0, 8'h00);
    frame(8'hF3, 8'h00, 1, 1'b0, 8'h00);
    frame(8'h21, 8'h00, 1, 1'b0, 8'h00);
    frame(8'h15, 8'h00, 1, 1'b0, 8'h00);
    bus(A_CTRL, 1'b1, 32'hFFFF_F7FF);
    check("t4_ss", spi_ss, 1);
    repeat (50) @(posedge clk);

    // EEPROM read back through the DUT
    use_ee = 1'b1;
    rd_tx  = '{8'h03, 8'h10, 8'h00, 8'h00, 8'h00};
    rd_exp = '{8'h00, 8'h00, 8'hF3, 8'h21, 8'h15};
    bus(A_CTRL, 1'b1, 32'h0000_1C01);
    for (int i = 0; i < 5; i++) frame(rd_tx[i], 8'h00, 1, (i >= 2), rd_exp[i]);
    bus(A_CTRL, 1'b1, 32'h0000_1001);
    check("t5_ss", spi_ss, 1);
    use_ee = 1'b0;

    // Randomized frames, slave select kept high
    for (int i = 0; i < 16; i++) begin
      tx  = 8'($urandom);
      slv = 8'($urandom);
      div = int'($urandom_range(0, 7));
      ie  = 1'($urandom);
      bus(A_CTRL, 1'b1, 32'h0000_1000 | (32'(ie) << 10) | 32'(div));
      frame(tx, slv, div, 1'b1, slv);
      check("rnd_din", wb_din, {16'h0, 2'b00, 1'b0, 1'b1, 1'b0, ie, 1'b1, 1'b0, slv});
      check("rnd_irq", irq, ie);
    end

    // DATA write while busy is ignored
    bus(A_CTRL, 1'b1, 32'h0000_1003);
    start_frame(8'hA5, 8'h3C);
    repeat (6) @(posedge clk);
    bus(A_DATA, 1'b1, 32'h0000_005A);
    finish_frame(8'hA5, 3, 1'b1, 8'h3C);
    rx_prev = 8'h3C;

    // EN cleared mid-frame aborts
    start_frame(8'hC3, 8'h99);
    repeat (20) @(posedge clk);
    bus(A_CTRL, 1'b1, 32'h0000_0003);
    check("abort_sck", spi_sck, 0);
    check("abort_busy", wb_din[13], 0);
    check("abort_if", wb_din[9], 0);
    check("abort_rx", wb_din[7:0], rx_prev);
    div = n_rise;
    repeat (40) @(posedge clk);
    #1;
    check("abort_quiet", n_rise, div);

    // Asynchronous reset mid-frame
    bus(A_CTRL, 1'b1, 32'h0000_1C03);
    start_frame(8'hFF, 8'hFF);
    repeat (11) @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    check("arst_ss", spi_ss, 1);
    check("arst_sck", spi_sck, 0);
    check("arst_din", wb_din, 0);
    check("arst_irq", irq, 0);
    check("arst_mosi", spi_mosi, 0);
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(posedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
